// File: rtl/tpu_dma_pkg.sv
// Shared types and helpers for the TPU AXI4 DMA copy engine.
package tpu_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam int         PAGE_BYTES     = 4096;

  // Beats in the next burst: bounded by what remains, the buffer, and both 4KB pages.
  function automatic logic [8:0] calc_blen(input logic [31:0] rem, input logic [8:0] max_b,
                                           input logic [11:0] src_off, input logic [11:0] dst_off);
    logic [12:0] s_room, d_room;
    logic [31:0] b;
    s_room = (13'(PAGE_BYTES) - {1'b0, src_off}) >> 3;
    d_room = (13'(PAGE_BYTES) - {1'b0, dst_off}) >> 3;
    b = rem;
    if (b > 32'(max_b))  b = 32'(max_b);
    if (b > 32'(s_room)) b = 32'(s_room);
    if (b > 32'(d_room)) b = 32'(d_room);
    return 9'(b);
  endfunction

endpackage

// File: rtl/tpu_axi4_dma_master_if.sv
// AXI4 bus bundle between the DMA master and the interconnect.
interface tpu_axi4_dma_master_if #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4
);
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/tpu_dma_buf.sv
// Burst staging buffer: one write port, combinational read port, no reset.
module tpu_dma_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 64,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/tpu_axi4_dma_master.sv
// AXI4 copy engine: read burst into local buffer, then write it out, one transaction at a time.
// Optional busy-cycle counter enabled by defining TPU_DMA_PERF_EN.
module tpu_axi4_dma_master
  import tpu_dma_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int DMA_ID         = 0,
  parameter int MAX_BURST      = 16,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_src,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_dst,
  input  logic [LEN_WIDTH-1:0]      cfg_beats,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [31:0]               perf_cycles,
  tpu_axi4_dma_master_if.master     m_axi
);
  localparam int BAW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  dma_state_e                state_q;
  logic [AXI_ADDR_WIDTH-1:0] src_q, dst_q, src_d, dst_d;
  logic [LEN_WIDTH-1:0]      rem_q, rem_d;
  logic [8:0]                blen_q, idx_q, blen_first, blen_next;
  logic cfg_err_q, bus_err_q, done_q, busy_q, cfg_ready_q;
  logic arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic cfg_bad, b_bad, last_beat, unused_ids;
  logic [AXI_DATA_WIDTH-1:0] rd_data;

  assign src_d      = src_q + (AXI_ADDR_WIDTH'(blen_q) << 3);
  assign dst_d      = dst_q + (AXI_ADDR_WIDTH'(blen_q) << 3);
  assign rem_d      = rem_q - LEN_WIDTH'(blen_q);
  assign blen_first = calc_blen(32'(rem_q), 9'(MAX_BURST), src_q[11:0], dst_q[11:0]);
  assign blen_next  = calc_blen(32'(rem_d), 9'(MAX_BURST), src_d[11:0], dst_d[11:0]);
  assign cfg_bad    = (src_q[2:0] != 3'd0) || (dst_q[2:0] != 3'd0) || (rem_q == '0);
  assign b_bad      = (m_axi.bresp != AXI_RESP_OKAY);
  assign last_beat  = (idx_q == blen_q - 9'd1);
  assign unused_ids = ^{m_axi.rid, m_axi.bid};

  tpu_dma_buf #(.DEPTH(MAX_BURST), .DW(AXI_DATA_WIDTH), .AW(BAW)) u_buf (
    .clk   (clk),
    .we    (rready_q && m_axi.rvalid && (idx_q < 9'(MAX_BURST))),
    .waddr (idx_q[BAW-1:0]),
    .wdata (m_axi.rdata),
    .raddr (idx_q[BAW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      blen_q    <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      bus_err_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (cfg_valid) begin
          src_q <= cfg_src; dst_q <= cfg_dst; rem_q <= cfg_beats;
          cfg_err_q <= 1'b0; bus_err_q <= 1'b0;
          busy_q <= 1'b1; cfg_ready_q <= 1'b0;
          state_q <= S_CHK;
        end
        S_CHK: if (cfg_bad) begin
          cfg_err_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1;
          state_q <= S_DONE;
        end else begin
          blen_q <= blen_first; arvalid_q <= 1'b1;
          state_q <= S_AR;
        end
        S_AR: if (m_axi.arready) begin
          arvalid_q <= 1'b0; rready_q <= 1'b1; idx_q <= '0;
          state_q <= S_R;
        end
        // Error beats are still drained so the slave sees a complete burst.
        S_R: if (m_axi.rvalid) begin
          idx_q <= idx_q + 9'd1;
          if (m_axi.rresp != AXI_RESP_OKAY) bus_err_q <= 1'b1;
          if (m_axi.rlast) begin
            rready_q <= 1'b0; awvalid_q <= 1'b1; idx_q <= '0;
            state_q <= S_AW;
          end
        end
        S_AW: if (m_axi.awready) begin
          awvalid_q <= 1'b0; wvalid_q <= 1'b1;
          state_q <= S_W;
        end
        S_W: if (m_axi.wready) begin
          if (last_beat) begin
            wvalid_q <= 1'b0; bready_q <= 1'b1;
            state_q <= S_B;
          end else begin
            idx_q <= idx_q + 9'd1;
          end
        end
        S_B: if (m_axi.bvalid) begin
          bready_q <= 1'b0;
          src_q <= src_d; dst_q <= dst_d; rem_q <= rem_d;
          if (b_bad) bus_err_q <= 1'b1;
          if ((rem_d != '0) && !bus_err_q && !b_bad) begin
            blen_q <= blen_next; arvalid_q <= 1'b1;
            state_q <= S_AR;
          end else begin
            busy_q <= 1'b0; done_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cfg_ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TPU_DMA_PERF_EN
  logic [31:0] cnt_q, perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && cfg_valid) cnt_q <= '0;
      else if (busy_q && (cnt_q != '1))      cnt_q <= cnt_q + 32'd1;
      if (state_q == S_DONE) perf_q <= cnt_q;
    end
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign cfg_ready     = cfg_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = {cfg_err_q, bus_err_q};
  assign m_axi.arid    = AXI_ID_WIDTH'(DMA_ID);
  assign m_axi.araddr  = src_q;
  assign m_axi.arlen   = 8'(blen_q - 9'd1);
  assign m_axi.arsize  = AXI_SIZE_8B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign m_axi.awid    = AXI_ID_WIDTH'(DMA_ID);
  assign m_axi.awaddr  = dst_q;
  assign m_axi.awlen   = 8'(blen_q - 9'd1);
  assign m_axi.awsize  = AXI_SIZE_8B;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = rd_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = last_beat;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
endmodule

// File: tb/tb_tpu_axi4_dma_master.sv
// Directed bench: vector table of transfers against a reactive AXI memory slave, plus reset/back-to-back sequences.
module tb_tpu_axi4_dma_master;
  logic        clk, rst_n;
  logic        cfg_valid, cfg_ready, busy, done;
  logic [31:0] cfg_src, cfg_dst, perf_cycles;
  logic [15:0] cfg_beats;
  logic [1:0]  err;

  tpu_axi4_dma_master_if #(.AW(32), .DW(64), .IDW(4)) m_axi ();

  tpu_axi4_dma_master dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_beats(cfg_beats),
    .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles), .m_axi(m_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit stall_en = 0;
  int err_beat = -1;
  int proto_err = 0;
  int r_total = 0;
  int ar_lens[$];
  int aw_lens[$];
  logic [63:0] mem [logic [31:0]];

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  function automatic logic [63:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  function automatic bit rdy();
    return !stall_en || ($urandom_range(0, 3) != 0);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory slave: every decision is taken on the falling edge for the next rising edge.
  initial begin : slave
    logic r_act, w_act, b_pend, ar_hold, aw_hold, w_hold, w_l_p;
    logic [31:0] ar_addr, aw_addr, ar_a_p, aw_a_p;
    logic [7:0]  ar_len, aw_len, ar_l_p, aw_l_p;
    logic [63:0] w_d_p;
    int rbeat, wbeat;
    {r_act, w_act, b_pend, ar_hold, aw_hold, w_hold} = '0;
    m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rlast = 0; m_axi.rdata = '0; m_axi.rresp = 0;
    m_axi.rid = 0; m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0; m_axi.bid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {r_act, w_act, b_pend, ar_hold, aw_hold, w_hold} = '0;
        m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rlast = 0;
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
      end else begin
        if (b_pend) begin
          m_axi.bvalid = rdy(); m_axi.bresp = 2'b00;
          if (m_axi.bvalid && m_axi.bready) b_pend = 0;
        end else m_axi.bvalid = 0;
        m_axi.wready = rdy();
        if (m_axi.wvalid) begin
          if (!w_act) proto_err++;
          if (w_hold && (m_axi.wdata != w_d_p || m_axi.wlast != w_l_p)) proto_err++;
          if (m_axi.wready && w_act) begin
            if (m_axi.wlast != (wbeat == int'(aw_len))) proto_err++;
            if (m_axi.wstrb != 8'hFF) proto_err++;
            mem[aw_addr + 32'(wbeat) * 32'd8] = m_axi.wdata;
            wbeat++;
            if (m_axi.wlast) begin w_act = 0; b_pend = 1; end
          end
        end
        w_hold = m_axi.wvalid && !m_axi.wready; w_d_p = m_axi.wdata; w_l_p = m_axi.wlast;
        if (m_axi.awvalid) begin
          if (aw_hold && (m_axi.awaddr != aw_a_p || m_axi.awlen != aw_l_p)) proto_err++;
          if (m_axi.awsize != 3'd3 || m_axi.awburst != 2'b01 || m_axi.awid != 4'd0) proto_err++;
          m_axi.awready = rdy();
          if (m_axi.awready) begin
            aw_lens.push_back(int'(m_axi.awlen) + 1);
            aw_addr = m_axi.awaddr; aw_len = m_axi.awlen; w_act = 1; wbeat = 0;
          end
        end else m_axi.awready = 0;
        aw_hold = m_axi.awvalid && !m_axi.awready; aw_a_p = m_axi.awaddr; aw_l_p = m_axi.awlen;
        if (r_act) begin
          m_axi.rvalid = rdy();
          m_axi.rdata  = rd(ar_addr + 32'(rbeat) * 32'd8);
          m_axi.rlast  = (rbeat == int'(ar_len));
          m_axi.rresp  = (r_total == err_beat) ? 2'b10 : 2'b00;
          if (m_axi.rvalid && m_axi.rready) begin
            rbeat++; r_total++;
            if (m_axi.rlast) r_act = 0;
          end
        end else begin m_axi.rvalid = 0; m_axi.rlast = 0; end
        if (m_axi.arvalid) begin
          if (ar_hold && (m_axi.araddr != ar_a_p || m_axi.arlen != ar_l_p)) proto_err++;
          if (m_axi.arsize != 3'd3 || m_axi.arburst != 2'b01 || m_axi.arid != 4'd0) proto_err++;
          m_axi.arready = !r_act && rdy();
          if (m_axi.arready) begin
            ar_lens.push_back(int'(m_axi.arlen) + 1);
            ar_addr = m_axi.araddr; ar_len = m_axi.arlen; r_act = 1; rbeat = 0;
          end
        end else m_axi.arready = 0;
        ar_hold = m_axi.arvalid && !m_axi.arready; ar_a_p = m_axi.araddr; ar_l_p = m_axi.arlen;
      end
    end
  end

  typedef struct packed {
    logic [31:0] src; logic [31:0] dst; logic [15:0] beats;
    int eb; logic st; logic [1:0] ee; int nb; int l0; int l1; int l2; int l3;
  } vec_t;

  function automatic vec_t mkv(input logic [31:0] s, input logic [31:0] d, input int b, input int eb,
                               input bit st, input logic [1:0] ee, input int nb,
                               input int l0, input int l1, input int l2, input int l3);
    vec_t v;
    v.src = s; v.dst = d; v.beats = 16'(b); v.eb = eb; v.st = st; v.ee = ee; v.nb = nb;
    v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3;
    return v;
  endfunction

  function automatic int exp_len(input vec_t v, input int i);
    case (i)
      0: return v.l0;
      1: return v.l1;
      2: return v.l2;
      default: return v.l3;
    endcase
  endfunction

  function automatic logic [9:0] outs();
    return {cfg_ready, busy, done, err, m_axi.arvalid, m_axi.rready, m_axi.awvalid, m_axi.wvalid, m_axi.bready};
  endfunction

  task automatic clear_model(input bit st, input int eb);
    stall_en = st; err_beat = eb; proto_err = 0; r_total = 0;
    mem.delete(); ar_lens.delete(); aw_lens.delete();
  endtask

  task automatic wait_done(input string name, output bit got, output int cyc);
    got = 0; cyc = 0;
    for (int n = 1; n <= 3000 && !got; n++) begin
      @(negedge clk); cyc = n;
      if (done) got = 1;
    end
    check({name, "_done_seen"}, got, 1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    bit got; int cyc, bad; string nm;
    nm = $sformatf("v%0d", k);
    clear_model(v.st, v.eb);
    @(negedge clk);
    cfg_src = v.src; cfg_dst = v.dst; cfg_beats = v.beats; cfg_valid = 1;
    @(negedge clk); cfg_valid = 0;
    if (done) begin got = 1; cyc = 1; check({nm, "_done_seen"}, got, 1); end
    else wait_done(nm, got, cyc);
    if (got) begin
      check({nm, "_busy_at_done"}, busy, 0);
      check({nm, "_err"}, err, v.ee);
      if (v.ee[1]) check({nm, "_cfgerr_within_3"}, cyc <= 3, 1);
      check({nm, "_ar_count"}, ar_lens.size(), v.nb);
      check({nm, "_aw_count"}, aw_lens.size(), v.nb);
      for (int i = 0; i < v.nb && i < ar_lens.size(); i++)
        check($sformatf("%s_ar_len%0d", nm, i), ar_lens[i], exp_len(v, i));
      for (int i = 0; i < v.nb && i < aw_lens.size(); i++)
        check($sformatf("%s_aw_len%0d", nm, i), aw_lens[i], exp_len(v, i));
      check({nm, "_protocol"}, proto_err, 0);
      if (v.ee == 2'b00) begin
        bad = 0;
        for (int i = 0; i < int'(v.beats); i++)
          if (rd(v.dst + 32'(i * 8)) != pat(v.src + 32'(i * 8))) bad++;
        check({nm, "_data_mismatches"}, bad, 0);
      end
      @(negedge clk);
      check({nm, "_ready_after_done"}, {cfg_ready, done, busy}, 3'b100);
    end
  endtask

  vec_t vecs[9];

  initial begin : main
    bit got; int cyc;
    rst_n = 0; cfg_valid = 0; cfg_src = 0; cfg_dst = 0; cfg_beats = 0;
    vecs[0] = mkv(32'h0000_1000, 32'h0000_8000,  4, -1, 0, 2'b00, 1,  4,  0, 0, 0);
    vecs[1] = mkv(32'h0000_0FF0, 32'h0002_0000, 10, -1, 0, 2'b00, 2,  2,  8, 0, 0);
    vecs[2] = mkv(32'h0000_2000, 32'h0000_9000, 40, -1, 0, 2'b00, 3, 16, 16, 8, 0);
    vecs[3] = mkv(32'h0000_1004, 32'h0000_8000,  4, -1, 0, 2'b10, 0,  0,  0, 0, 0);
    vecs[4] = mkv(32'h0000_3000, 32'h0000_A000, 32,  1, 0, 2'b01, 1, 16,  0, 0, 0);
    vecs[5] = mkv(32'h0000_4FE8, 32'h0000_B000, 20, -1, 1, 2'b00, 3,  3, 16, 1, 0);
    vecs[6] = mkv(32'h0000_6000, 32'h0000_CFC0, 12, -1, 1, 2'b00, 2,  8,  4, 0, 0);
    vecs[7] = mkv(32'h0000_1000, 32'h0000_8002,  4, -1, 0, 2'b10, 0,  0,  0, 0, 0);
    vecs[8] = mkv(32'h0000_1000, 32'h0000_8000,  0, -1, 0, 2'b10, 0,  0,  0, 0, 0);

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 10'b1_0_0_00_00000);
    check("reset_perf", perf_cycles, 0);
    rst_n = 1;

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    // Async reset while the write burst is in flight.
    clear_model(0, -1);
    @(negedge clk);
    cfg_src = 32'h7000; cfg_dst = 32'hD000; cfg_beats = 8; cfg_valid = 1;
    @(negedge clk); cfg_valid = 0;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (m_axi.wvalid) got = 1;
    end
    check("midw_reached_w", got, 1);
    @(negedge clk);
    rst_n = 0; #1;
    check("midw_reset_outputs", outs(), 10'b1_0_0_00_00000);
    check("midw_reset_perf", perf_cycles, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("midw_idle_after_reset", {cfg_ready, busy, done}, 3'b100);

    // Back-to-back: cfg_valid held through done starts a second transfer.
    clear_model(0, -1);
    @(negedge clk);
    cfg_src = 32'h1000; cfg_dst = 32'h8000; cfg_beats = 4; cfg_valid = 1;
    wait_done("b2b_first", got, cyc);
    @(negedge clk);
    check("b2b_ready_cycle", {cfg_ready, busy, done}, 3'b100);
    @(negedge clk);
    check("b2b_second_accepted", {cfg_ready, busy}, 2'b01);
    cfg_valid = 0;
    wait_done("b2b_second", got, cyc);
    check("b2b_err", err, 0);
    check("b2b_ar_count", ar_lens.size(), 2);
    check("b2b_data", rd(32'h8018), pat(32'h1018));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
